branch_predict_unit: RTL and testbench

- Parametrised successor to the EX-stage branch comparator. Resolves conditional branches for any operand width.
- Holds a bimodal branch history table (BHT) of 2-bit saturating counters. The IF stage reads it for predictions; the EX stage trains it.
- Compares the actual outcome with the prediction carried down the pipe, and produces a mispredict flag and redirect PC for the hazard/PC logic.
- Keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_predict_unit.sv | 132 +++++++++++++
 tb/tb_branch_predict_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
`default_nettype none
// =============================================================================
// branch_predict_unit: EX-stage branch resolve, bimodal 2-bit BHT, stats
// Rev 1.0
// =============================================================================
module branch_predict_unit #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          if_pc,
  output logic                 if_predTaken,
  input  logic                 ex_braEnable,
  input  logic                 ex_stall,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_target,
  input  logic [WIDTH-1:0]     ex_din1,
  input  logic [WIDTH-1:0]     ex_din2,
  input  logic [2:0]           ex_braOp,
  input  logic                 ex_predTaken,
  output logic                 takeBranch,
  output logic                 mispredict,
  output logic [31:0]          redirectPc,
  output logic [CNT_WIDTH-1:0] branchCount,
  output logic [CNT_WIDTH-1:0] mispredCount
);

  localparam int IDX = $clog2(BHT_DEPTH);

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_GEZ = 3'b010;
  localparam logic [2:0] OP_GTZ = 3'b011;
  localparam logic [2:0] OP_LEZ = 3'b100;
  localparam logic [2:0] OP_LTZ = 3'b101;

  localparam logic [1:0] BHT_RESET = 2'b01;
  localparam logic [1:0] BHT_MAX   = 2'b11;
  localparam logic [1:0] BHT_MIN   = 2'b00;

  logic                          cmp_valid;
  logic                          cmp_result;
  logic                          din1_neg;
  logic                          din1_zero;
  logic                          resolve;
  logic [IDX-1:0]                if_idx;
  logic [IDX-1:0]                ex_idx;
  logic [BHT_DEPTH-1:0][1:0]     bht_q;
  logic [BHT_DEPTH-1:0][1:0]     bht_d;
  logic [1:0]                    ex_entry;
  logic [CNT_WIDTH-1:0]          branch_cnt_q;
  logic [CNT_WIDTH-1:0]          branch_cnt_d;
  logic [CNT_WIDTH-1:0]          misp_cnt_q;
  logic [CNT_WIDTH-1:0]          misp_cnt_d;

  // Sign and zero tests avoid signed arithmetic entirely.
  assign din1_neg  = ex_din1[WIDTH-1];
  assign din1_zero = ~|ex_din1;

  always_comb begin
    cmp_valid  = 1'b1;
    cmp_result = 1'b0;
    case (ex_braOp)
      OP_EQ:   cmp_result = (ex_din1 == ex_din2);
      OP_NE:   cmp_result = (ex_din1 != ex_din2);
      OP_GEZ:  cmp_result = ~din1_neg;
      OP_GTZ:  cmp_result = ~din1_neg & ~din1_zero;
      OP_LEZ:  cmp_result = din1_neg | din1_zero;
      OP_LTZ:  cmp_result = din1_neg;
      default: cmp_valid  = 1'b0;
    endcase
  end

  assign takeBranch = ex_braEnable & cmp_result;
  assign mispredict = ex_braEnable & (takeBranch ^ ex_predTaken);
  assign redirectPc = takeBranch ? ex_target : (ex_pc + 32'd8);
  assign resolve    = ex_braEnable & ~ex_stall & cmp_valid;

  // Untagged direct-mapped index; aliasing between PCs is accepted.
  assign if_idx = if_pc[IDX+1:2];
  assign ex_idx = ex_pc[IDX+1:2];

  // Read straight from the registered table: no write-to-read bypass.
  assign if_predTaken = bht_q[if_idx][1];
  assign ex_entry     = bht_q[ex_idx];

  always_comb begin
    bht_d = bht_q;
    if (resolve) begin
      if (takeBranch) begin
        bht_d[ex_idx] = (ex_entry == BHT_MAX) ? BHT_MAX : ex_entry + 2'd1;
      end else begin
        bht_d[ex_idx] = (ex_entry == BHT_MIN) ? BHT_MIN : ex_entry - 2'd1;
      end
    end
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    misp_cnt_d   = misp_cnt_q;
    if (resolve) begin
      if (!(&branch_cnt_q)) begin
        branch_cnt_d = branch_cnt_q + 1'b1;
      end
      if (mispredict && !(&misp_cnt_q)) begin
        misp_cnt_d = misp_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bht_q        <= {BHT_DEPTH{BHT_RESET}};
      branch_cnt_q <= '0;
      misp_cnt_q   <= '0;
    end else begin
      bht_q        <= bht_d;
      branch_cnt_q <= branch_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end

  assign branchCount  = branch_cnt_q;
  assign mispredCount = misp_cnt_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:IDX+2], if_pc[1:0], ex_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// =============================================================================
// tb_branch_predict_unit: directed scoreboard bench for branch_predict_unit
// Rev 1.0
// =============================================================================
module tb_branch_predict_unit;

  localparam int M_TB    = 1;
  localparam int M_MP    = 2;
  localparam int M_RPC   = 4;
  localparam int M_PRED  = 8;
  localparam int M_BC    = 16;
  localparam int M_MC    = 32;
  localparam int M_S     = 64;
  localparam int M_BCS   = 128;
  localparam int M_MCS   = 256;
  localparam int M_PREDS = 512;

  typedef struct {
    string       name;
    int          m;
    logic        tb;
    logic        mp;
    logic [31:0] rpc;
    logic        pred;
    logic [15:0] bc;
    logic [15:0] mc;
    logic        tbs;
    logic        mps;
    logic [3:0]  bcs;
    logic [3:0]  mcs;
    logic        preds;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        ex_braEnable;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic [31:0] ex_din1;
  logic [31:0] ex_din2;
  logic [2:0]  ex_braOp;
  logic        ex_predTaken;

  logic        if_predTaken;
  logic        takeBranch;
  logic        mispredict;
  logic [31:0] redirectPc;
  logic [15:0] branchCount;
  logic [15:0] mispredCount;

  logic        s_predTaken;
  logic        s_takeBranch;
  logic        s_mispredict;
  logic [31:0] s_redirectPc;
  logic [3:0]  s_branchCount;
  logic [3:0]  s_mispredCount;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  branch_predict_unit #(.WIDTH(32), .BHT_DEPTH(64), .CNT_WIDTH(16)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .if_pc        (if_pc),
    .if_predTaken (if_predTaken),
    .ex_braEnable (ex_braEnable),
    .ex_stall     (ex_stall),
    .ex_pc        (ex_pc),
    .ex_target    (ex_target),
    .ex_din1      (ex_din1),
    .ex_din2      (ex_din2),
    .ex_braOp     (ex_braOp),
    .ex_predTaken (ex_predTaken),
    .takeBranch   (takeBranch),
    .mispredict   (mispredict),
    .redirectPc   (redirectPc),
    .branchCount  (branchCount),
    .mispredCount (mispredCount)
  );

  branch_predict_unit #(.WIDTH(8), .BHT_DEPTH(4), .CNT_WIDTH(4)) u_small (
    .clk          (clk),
    .rst          (rst),
    .if_pc        (if_pc),
    .if_predTaken (s_predTaken),
    .ex_braEnable (ex_braEnable),
    .ex_stall     (ex_stall),
    .ex_pc        (ex_pc),
    .ex_target    (ex_target),
    .ex_din1      (ex_din1[7:0]),
    .ex_din2      (ex_din2[7:0]),
    .ex_braOp     (ex_braOp),
    .ex_predTaken (ex_predTaken),
    .takeBranch   (s_takeBranch),
    .mispredict   (s_mispredict),
    .redirectPc   (s_redirectPc),
    .branchCount  (s_branchCount),
    .mispredCount (s_mispredCount)
  );

  task automatic chk(input string nm, input string f, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
    end
  endtask

  // Monitor: every negedge, pop the expectation queued for this cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      if ((cur.m & M_TB)  != 0) chk(cur.name, "takeBranch", {31'd0, takeBranch}, {31'd0, cur.tb});
      if ((cur.m & M_MP)  != 0) chk(cur.name, "mispredict", {31'd0, mispredict}, {31'd0, cur.mp});
      if ((cur.m & M_RPC) != 0) chk(cur.name, "redirectPc", redirectPc, cur.rpc);
      if ((cur.m & M_PRED) != 0) chk(cur.name, "if_predTaken", {31'd0, if_predTaken}, {31'd0, cur.pred});
      if ((cur.m & M_BC)  != 0) chk(cur.name, "branchCount", {16'd0, branchCount}, {16'd0, cur.bc});
      if ((cur.m & M_MC)  != 0) chk(cur.name, "mispredCount", {16'd0, mispredCount}, {16'd0, cur.mc});
      if ((cur.m & M_S)   != 0) begin
        chk(cur.name, "w8_takeBranch", {31'd0, s_takeBranch}, {31'd0, cur.tbs});
        chk(cur.name, "w8_mispredict", {31'd0, s_mispredict}, {31'd0, cur.mps});
      end
      if ((cur.m & M_BCS) != 0) chk(cur.name, "w8_branchCount", {28'd0, s_branchCount}, {28'd0, cur.bcs});
      if ((cur.m & M_MCS) != 0) chk(cur.name, "w8_mispredCount", {28'd0, s_mispredCount}, {28'd0, cur.mcs});
      if ((cur.m & M_PREDS) != 0) chk(cur.name, "w8_if_predTaken", {31'd0, s_predTaken}, {31'd0, cur.preds});
    end
  end

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input string nm, input int m, input logic tb, input logic mp,
                     input logic [31:0] rpc, input logic pred, input logic [15:0] bc,
                     input logic [15:0] mc, input logic tbs, input logic [3:0] bcs,
                     input logic [3:0] mcs, input logic preds);
    exp_t e;
    e.name = nm;  e.m = m;  e.tb = tb;  e.mp = mp;  e.rpc = rpc;  e.pred = pred;
    e.bc = bc;  e.mc = mc;  e.tbs = tbs;  e.bcs = bcs;  e.mcs = mcs;  e.preds = preds;
    e.mps = ex_braEnable & (tbs ^ ex_predTaken);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ex_braEnable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cmp(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2,
                     input logic tb, input logic tbs);
    ex_braEnable = 1'b1;  ex_stall = 1'b1;  ex_predTaken = 1'b0;
    ex_pc = 32'h1000;  ex_target = 32'h2000;
    ex_braOp = op;  ex_din1 = d1;  ex_din2 = d2;
    cyc("compare", M_TB | M_MP | M_RPC | M_BC | M_S, tb, tb,
        tb ? 32'h2000 : 32'h1008, 1'b0, 16'd0, 16'd0, tbs, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;  if_pc = '0;  ex_braEnable = 1'b0;  ex_stall = 1'b0;
    ex_pc = '0;  ex_target = '0;  ex_din1 = '0;  ex_din2 = '0;
    ex_braOp = 3'b000;  ex_predTaken = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state across every table index.
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i) << 2;
      cyc("reset_sweep", M_PRED | M_BC | M_MC | M_BCS | M_MCS | M_PREDS,
          0, 0, 0, 1'b0, 16'd0, 16'd0, 0, 4'd0, 4'd0, 1'b0);
    end

    // Comparator, held in stall so the table is untouched.
    cmp(3'b000, 32'h1234, 32'h1234, 1, 1);
    cmp(3'b001, 32'h1234, 32'h1234, 0, 0);
    cmp(3'b000, 32'h1234, 32'h1235, 0, 0);
    cmp(3'b001, 32'h1234, 32'h1235, 1, 1);
    cmp(3'b010, 32'h0, 32'h0, 1, 1);
    cmp(3'b011, 32'h0, 32'h0, 0, 0);
    cmp(3'b100, 32'h0, 32'h0, 1, 1);
    cmp(3'b101, 32'h0, 32'h0, 0, 0);
    cmp(3'b010, 32'h1, 32'h0, 1, 1);
    cmp(3'b011, 32'h1, 32'h0, 1, 1);
    cmp(3'b100, 32'h1, 32'h0, 0, 0);
    cmp(3'b101, 32'h1, 32'h0, 0, 0);
    cmp(3'b010, 32'h80000000, 32'h0, 0, 1);
    cmp(3'b011, 32'h80000000, 32'h0, 0, 0);
    cmp(3'b100, 32'h80000000, 32'h0, 1, 1);
    cmp(3'b101, 32'h80000000, 32'h0, 1, 0);
    cmp(3'b010, 32'h80, 32'h0, 1, 0);
    cmp(3'b011, 32'h80, 32'h0, 1, 0);
    cmp(3'b100, 32'h80, 32'h0, 0, 1);
    cmp(3'b101, 32'h80, 32'h0, 0, 1);
    cmp(3'b011, 32'hFFFFFFFF, 32'h0, 0, 0);
    cmp(3'b100, 32'hFFFFFFFF, 32'h0, 1, 1);
    cmp(3'b110, 32'h5, 32'h5, 0, 0);
    cmp(3'b111, 32'h5, 32'h5, 0, 0);

    // Training a taken beq at 0x100.
    do_reset();
    ex_stall = 1'b0;  ex_braEnable = 1'b1;  ex_braOp = 3'b000;
    ex_din1 = 32'd5;  ex_din2 = 32'd5;  ex_pc = 32'h100;  ex_target = 32'h300;
    if_pc = 32'h100;  ex_predTaken = 1'b0;
    cyc("train1", M_TB | M_MP | M_RPC | M_PRED | M_BC | M_MC | M_BCS | M_S,
        1, 1, 32'h300, 1'b0, 16'd0, 16'd0, 1, 4'd0, 4'd0, 1'b0);
    cyc("train2", M_TB | M_MP | M_PRED | M_BC | M_MC | M_BCS,
        1, 1, 0, 1'b1, 16'd1, 16'd1, 1, 4'd1, 4'd0, 1'b0);
    ex_predTaken = 1'b1;
    cyc("train3", M_TB | M_MP | M_PRED | M_BC | M_MC | M_BCS,
        1, 0, 0, 1'b1, 16'd2, 16'd2, 1, 4'd2, 4'd0, 1'b0);
    ex_braEnable = 1'b0;  if_pc = 32'h200;
    cyc("alias_read", M_TB | M_MP | M_PRED | M_BC | M_MC | M_BCS,
        0, 0, 0, 1'b1, 16'd3, 16'd2, 0, 4'd3, 4'd0, 1'b0);
    if_pc = 32'h104;
    cyc("neighbour_read", M_PRED, 0, 0, 0, 1'b0, 16'd3, 16'd2, 0, 4'd0, 4'd0, 1'b0);

    // Not-taken on the aliasing PC, reading the shared entry in the same cycle.
    ex_braEnable = 1'b1;  ex_pc = 32'h200;  ex_din2 = 32'd6;  ex_predTaken = 1'b1;
    if_pc = 32'h100;
    cyc("alias_nt1", M_TB | M_MP | M_RPC | M_PRED | M_BC | M_MC,
        0, 1, 32'h208, 1'b1, 16'd3, 16'd2, 0, 4'd0, 4'd0, 1'b0);
    cyc("alias_nt2", M_TB | M_MP | M_PRED | M_BC | M_MC,
        0, 1, 0, 1'b1, 16'd4, 16'd3, 0, 4'd0, 4'd0, 1'b0);
    ex_braEnable = 1'b0;
    cyc("alias_after", M_TB | M_MP | M_PRED | M_BC | M_MC,
        0, 0, 0, 1'b0, 16'd5, 16'd4, 0, 4'd0, 4'd0, 1'b0);

    // Redirect PC, stalled so counts stay put.
    ex_braEnable = 1'b1;  ex_stall = 1'b1;  ex_braOp = 3'b001;
    ex_din1 = 32'd9;  ex_din2 = 32'd9;  ex_pc = 32'hFFFFFFFC;  ex_predTaken = 1'b1;
    cyc("redirect_wrap", M_TB | M_MP | M_RPC | M_BC | M_MC,
        0, 1, 32'h00000004, 1'b0, 16'd5, 16'd4, 0, 4'd0, 4'd0, 1'b0);
    ex_braOp = 3'b000;  ex_predTaken = 1'b0;  ex_target = 32'h400;
    cyc("redirect_target", M_TB | M_MP | M_RPC | M_BC | M_MC,
        1, 1, 32'h400, 1'b0, 16'd5, 16'd4, 0, 4'd0, 4'd0, 1'b0);

    // Stall held for 4 cycles, then released.
    do_reset();
    ex_braEnable = 1'b1;  ex_stall = 1'b1;  ex_braOp = 3'b000;
    ex_din1 = 32'd7;  ex_din2 = 32'd7;  ex_pc = 32'h40;  ex_target = 32'h80;
    if_pc = 32'h40;  ex_predTaken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc("stall_hold", M_TB | M_MP | M_PRED | M_BC | M_MC,
          1, 1, 0, 1'b0, 16'd0, 16'd0, 0, 4'd0, 4'd0, 1'b0);
    end
    ex_stall = 1'b0;
    cyc("stall_release", M_TB | M_MP | M_PRED | M_BC | M_MC,
        1, 1, 0, 1'b0, 16'd0, 16'd0, 0, 4'd0, 4'd0, 1'b0);
    ex_braEnable = 1'b0;
    cyc("stall_after1", M_PRED | M_BC | M_MC, 0, 0, 0, 1'b1, 16'd1, 16'd1, 0, 4'd0, 4'd0, 1'b0);
    cyc("stall_after2", M_PRED | M_BC | M_MC, 0, 0, 0, 1'b1, 16'd1, 16'd1, 0, 4'd0, 4'd0, 1'b0);

    // Invalid ops: mispredict still flags, nothing else moves.
    ex_braEnable = 1'b1;  ex_braOp = 3'b110;  ex_predTaken = 1'b1;
    cyc("invalid_op6", M_TB | M_MP | M_RPC | M_PRED | M_BC | M_MC,
        0, 1, 32'h48, 1'b1, 16'd1, 16'd1, 0, 4'd0, 4'd0, 1'b0);
    ex_braOp = 3'b111;
    cyc("invalid_op7", M_TB | M_MP | M_PRED | M_BC | M_MC,
        0, 1, 0, 1'b1, 16'd1, 16'd1, 0, 4'd0, 4'd0, 1'b0);
    ex_braEnable = 1'b0;
    cyc("invalid_after", M_PRED | M_BC | M_MC, 0, 0, 0, 1'b1, 16'd1, 16'd1, 0, 4'd0, 4'd0, 1'b0);

    // Counter saturation on the 4-bit instance.
    do_reset();
    ex_braEnable = 1'b1;  ex_stall = 1'b0;  ex_braOp = 3'b000;
    ex_din1 = 32'd3;  ex_din2 = 32'd3;  ex_pc = 32'h100;  ex_predTaken = 1'b1;
    if_pc = 32'h100;
    for (int k = 0; k < 20; k++) begin
      cyc("saturate", M_BC | M_MC | M_BCS | M_MCS, 0, 0, 0, 1'b0, 16'(k), 16'd0,
          0, (k > 15) ? 4'd15 : 4'(k), 4'd0, 1'b0);
    end
    ex_braEnable = 1'b0;
    cyc("saturate_end", M_BC | M_MC | M_BCS | M_MCS | M_PRED | M_PREDS,
        0, 0, 0, 1'b1, 16'd20, 16'd0, 0, 4'd15, 4'd0, 1'b1);

    // Reset coincident with a mispredicting resolve.
    rst = 1'b1;  ex_braEnable = 1'b1;  ex_predTaken = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;  ex_braEnable = 1'b0;
    cyc("midrun_reset", M_PRED | M_BC | M_MC | M_BCS | M_MCS | M_PREDS,
        0, 0, 0, 1'b0, 16'd0, 16'd0, 0, 4'd0, 4'd0, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
